dsp_arbiter: RTL and testbench
==============================

# dsp_arbiter

Round-robin arbiter that shares one left/right DSP slice pair between up to N_CLIENTS sequencers (FIR interpolators, filters, mixers) using the codebase's flat DSP bus format. Each client requests the pair, holds it for a whole MAC burst, then releases it. The arbiter muxes the granted client's 92-bit input buses onto the slices and broadcasts the 48-bit P outputs to all clients. A one-cycle flush between owners clears the accumulator so no partial sum leaks from one client to the next.

## Interface
- N_CLIENTS, 4: number of requesters, range 2..8.
- OWNER_W, 3: width of `dsp_owner`; must be ≥ clog2(N_CLIENTS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- client_req  in  N_CLIENTS  per-client request/hold level.
- client_grant  out  N_CLIENTS  one-hot or zero grant, registered.
- client_ins_flat_l  in  N_CLIENTS*92  client c drives bits [c*92+91 : c*92] as {opmode[7:0], a[17:0], b[17:0], c[47:0]}.
- client_ins_flat_r  in  N_CLIENTS*92  same layout, right channel.
- client_outs_flat_l  out  48  P of the left slice, broadcast to all clients.
- client_outs_flat_r  out  48  P of the right slice, broadcast to all clients.
- dsp_ins_flat_l  out  92  to the left DSP slice.
- dsp_ins_flat_r  out  92  to the right DSP slice.
- dsp_outs_flat_l  in  48  from the left DSP slice.
- dsp_outs_flat_r  in  48  from the right DSP slice.
- dsp_busy  out  1  high while any grant is asserted.
- dsp_owner  out  OWNER_W  index of the granted client; 0 when idle.

## Operation
- NOP bus is {`DSP_NOP`, 18'h0, 18'h0, 48'h0}. It is driven on both dsp_ins_flat ports whenever no grant is active.
- The input mux is combinational on the registered grant: dsp_ins_flat_l/r = the granted client's slice, otherwise the NOP bus.
- client_outs_flat_l/r = dsp_outs_flat_l/r, passed straight through with no register.
- FSM states:
  - IDLE: if any req is set, pick the winner and register its grant -> GRANT. Otherwise stay in IDLE.
  - GRANT: hold the grant while the owner's req stays high. Requests from other clients are ignored. When the owner's req is low -> FLUSH, and the grant clears on the same edge.
  - FLUSH: drive the NOP bus for exactly one cycle. Arbitrate among current reqs. If there is a winner, register its grant -> GRANT; otherwise -> IDLE.
- Round-robin rule: search starts at (last_owner+1) mod N_CLIENTS and takes the first set req. last_owner updates on every grant. After reset, last_owner = N_CLIENTS-1, so client 0 has highest priority.
- There is no hold timeout. A client that never releases starves the others; this is the client's responsibility.
- A non-owner may drop req before it is granted without side effects.
- Owner protocol:
  - The first operation is issued in the first cycle grant is seen high.
  - P is read while the grant is still held.
  - The owner drives its own NOP during the cycle it drops req.
- dsp_busy = |client_grant. dsp_owner is registered alongside the grant.

## Timing
- Reset values: client_grant=0, dsp_busy=0, dsp_owner=0, FSM=IDLE, last_owner=N_CLIENTS-1. dsp_ins_flat_l/r carry the NOP bus; client_outs follow dsp_outs.
- Reset mid-burst: the grant drops asynchronously and the bus becomes NOP immediately. A client must restart its burst after reset.
- Request latency from IDLE: req high sampled at edge t gives grant high after edge t (cycle t+1).
- Release: owner req low in cycle t; grant low in cycle t+1 (FLUSH, NOP bus); next owner granted in cycle t+2 at the earliest.
- Owner-to-owner gap is exactly one NOP cycle.
- Simultaneous requests are resolved by round-robin only; a grant never changes without a FLUSH cycle in between.
- At most one grant bit is ever set.

## Test plan
- Reset, then client 1 holds req for 10 cycles -> grant=4'b0010 from cycle 1 to cycle 10; dsp_ins_flat_l equals client 1's bus during the grant and the NOP bus otherwise; dsp_owner=1.
- After reset, all four reqs rise together, and each owner drops req 3 cycles after its grant -> grants go 0,1,2,3 in order with exactly one FLUSH NOP cycle between owners.
- Client 2 holds req while clients 0 and 3 request -> grant to 2 never changes; after 2 releases, client 3 is granted before 0.
- Owner drops req in cycle t while client 0 requests -> grant=0 and the NOP bus in cycle t+1; client 0 is granted in cycle t+2.
- Force dsp_outs_flat_l=48'h0000_1234_5678 -> client_outs_flat_l shows the same value in the same cycle, whatever the grant.
- Assert reset in the middle of a grant -> grant=0 asynchronously, NOP bus, and after release client 0 wins priority again.

Source files
------------

// File: rtl/dsp_arbiter.sv
// -----------------------------------------------------------------------------
// dsp_arbiter
//
// Purpose:
//   Shares one left/right DSP slice pair between N_CLIENTS sequencers. A client
//   raises its request, keeps it high for a whole MAC burst and then drops it.
//   The owner keeps the slices for as long as its request stays high. Other
//   clients wait until the owner lets go.
//
//   Between two owners there is always exactly one FLUSH cycle. During that
//   cycle the slices see the NOP bus, so no partial sum from one owner reaches
//   the next one.
//
//   The next owner is chosen round-robin. The search starts at the client
//   after the last owner.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   client_req          per-client request/hold level
//   client_grant        registered grant, one-hot or zero
//   client_ins_flat_l   client c drives [c*92+91:c*92] = {opmode,a,b,c}, left
//   client_ins_flat_r   same layout, right channel
//   client_outs_flat_l  left slice P, broadcast to all clients (no register)
//   client_outs_flat_r  right slice P, broadcast to all clients (no register)
//   dsp_ins_flat_l      bus to the left DSP slice
//   dsp_ins_flat_r      bus to the right DSP slice
//   dsp_outs_flat_l     P from the left DSP slice
//   dsp_outs_flat_r     P from the right DSP slice
//   dsp_busy            high while any grant is asserted
//   dsp_owner           index of the granted client, 0 when idle
// -----------------------------------------------------------------------------
module dsp_arbiter #(
  parameter int         N_CLIENTS  = 4,
  parameter int         OWNER_W    = 3,
  parameter logic [7:0] NOP_OPMODE = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CLIENTS-1:0]     client_req,
  output logic [N_CLIENTS-1:0]     client_grant,
  input  logic [N_CLIENTS*92-1:0]  client_ins_flat_l,
  input  logic [N_CLIENTS*92-1:0]  client_ins_flat_r,
  output logic [47:0]              client_outs_flat_l,
  output logic [47:0]              client_outs_flat_r,
  output logic [91:0]              dsp_ins_flat_l,
  output logic [91:0]              dsp_ins_flat_r,
  input  logic [47:0]              dsp_outs_flat_l,
  input  logic [47:0]              dsp_outs_flat_r,
  output logic                     dsp_busy,
  output logic [OWNER_W-1:0]       dsp_owner
);

  localparam int BUS_W = 92;

  // The NOP bus is the NOP opmode with all operands set to zero.
  localparam logic [BUS_W-1:0] NOP_BUS = {NOP_OPMODE, 18'h0, 18'h0, 48'h0};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_owner_q, last_owner_d;

  logic                 win_valid;
  logic [OWNER_W-1:0]   win_idx;
  logic                 owner_req;
  logic [BUS_W-1:0]     mux_l;
  logic [BUS_W-1:0]     mux_r;

  // Round-robin pick. The search walks the clients in order, starting at
  // last_owner+1 and wrapping around. Because the last owner is visited
  // last, it only wins again when nobody else is asking.
  always_comb begin
    int                   idx;
    logic [N_CLIENTS-1:0] req_shift;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    req_shift = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      idx       = (int'(last_owner_q) + k) % N_CLIENTS;
      req_shift = client_req >> idx;
      if (!win_valid && req_shift[0]) begin
        win_valid = 1'b1;
        win_idx   = OWNER_W'(idx);
      end
    end
  end

  // The grant is one-hot, so masking the requests with it yields the
  // owner's own request bit.
  assign owner_req = |(client_req & grant_q);

  // Next-state logic. IDLE and FLUSH arbitrate the same way. FLUSH differs
  // only in that it comes straight after a release, so it is the single NOP
  // cycle between owners. In GRANT the other clients' requests are
  // deliberately ignored.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE, ST_FLUSH: begin
        if (win_valid) begin
          grant_d      = N_CLIENTS'(1) << win_idx;
          owner_d      = win_idx;
          last_owner_d = win_idx;
          state_d      = ST_GRANT;
        end else begin
          grant_d = '0;
          owner_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          grant_d = '0;
          owner_d = '0;
          state_d = ST_FLUSH;
        end
      end
      default: begin
        grant_d = '0;
        owner_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and owner registers. last_owner resets to the highest
  // index, so client 0 is searched first after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OWNER_W'(N_CLIENTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Input mux. It is driven only from the registered grant, so a reset
  // clears the grant and puts the NOP bus on the slices at once.
  always_comb begin
    mux_l = NOP_BUS;
    mux_r = NOP_BUS;
    for (int c = 0; c < N_CLIENTS; c++) begin
      if (grant_q[c]) begin
        mux_l = client_ins_flat_l[c*BUS_W +: BUS_W];
        mux_r = client_ins_flat_r[c*BUS_W +: BUS_W];
      end
    end
  end

  assign dsp_ins_flat_l     = mux_l;
  assign dsp_ins_flat_r     = mux_r;
  assign client_outs_flat_l = dsp_outs_flat_l;
  assign client_outs_flat_r = dsp_outs_flat_r;
  assign client_grant       = grant_q;
  assign dsp_busy           = |grant_q;
  assign dsp_owner          = owner_q;

endmodule

// File: tb/tb_dsp_arbiter.sv
// Bench for dsp_arbiter: directed stimulus, a round-robin ownership model and
// per-cycle comparison, plus hand-computed literal checks.
module tb_dsp_arbiter;

  localparam int         N      = 4;
  localparam int         OW     = 3;
  localparam logic [7:0] NOP_OP = 8'h3C;
  localparam logic [91:0] NOP_BUS = {8'h3C, 18'h0, 18'h0, 48'h0};

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    client_req = '0;
  logic [N-1:0]    client_grant;
  logic [N*92-1:0] client_ins_flat_l;
  logic [N*92-1:0] client_ins_flat_r;
  logic [47:0]     client_outs_flat_l;
  logic [47:0]     client_outs_flat_r;
  logic [91:0]     dsp_ins_flat_l;
  logic [91:0]     dsp_ins_flat_r;
  logic [47:0]     dsp_outs_flat_l = 48'h0;
  logic [47:0]     dsp_outs_flat_r = 48'h0;
  logic            dsp_busy;
  logic [OW-1:0]   dsp_owner;

  logic [91:0] ins_l [N];
  logic [91:0] ins_r [N];

  int total = 0;
  int bad   = 0;

  // Model state: the current owner (-1 when nobody holds the slices) and the
  // last client that was granted.
  int m_owner = -1;
  int m_last  = N - 1;

  dsp_arbiter #(.N_CLIENTS(N), .OWNER_W(OW), .NOP_OPMODE(NOP_OP)) dut (
    .clk                (clk),
    .reset              (reset),
    .client_req         (client_req),
    .client_grant       (client_grant),
    .client_ins_flat_l  (client_ins_flat_l),
    .client_ins_flat_r  (client_ins_flat_r),
    .client_outs_flat_l (client_outs_flat_l),
    .client_outs_flat_r (client_outs_flat_r),
    .dsp_ins_flat_l     (dsp_ins_flat_l),
    .dsp_ins_flat_r     (dsp_ins_flat_r),
    .dsp_outs_flat_l    (dsp_outs_flat_l),
    .dsp_outs_flat_r    (dsp_outs_flat_r),
    .dsp_busy           (dsp_busy),
    .dsp_owner          (dsp_owner)
  );

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_flat
      assign client_ins_flat_l[g*92 +: 92] = ins_l[g];
      assign client_ins_flat_r[g*92 +: 92] = ins_r[g];
    end
  endgenerate

  // Round-robin pick: the first requesting client after 'last', wrapping
  // around. Returns -1 when no client is requesting.
  function automatic int rrPick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Ownership rules. The owner keeps the slices while its request is high.
  // A free slice pair goes to the round-robin winner. Going through "no
  // owner" after a release gives the single flush cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= -1;
      m_last  <= N - 1;
    end else if (m_owner >= 0) begin
      if (!client_req[m_owner]) m_owner <= -1;
    end else begin
      int w;
      w = rrPick(client_req, m_last);
      if (w >= 0) begin
        m_owner <= w;
        m_last  <= w;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0]  eg;
    logic [91:0]   el, er;
    logic [OW-1:0] eo;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    el = (m_owner >= 0) ? ins_l[m_owner] : NOP_BUS;
    er = (m_owner >= 0) ? ins_r[m_owner] : NOP_BUS;
    eo = (m_owner >= 0) ? OW'(m_owner) : '0;
    checkOutput("cyc_grant", 128'(client_grant), 128'(eg));
    checkOutput("cyc_owner", 128'(dsp_owner), 128'(eo));
    checkOutput("cyc_busy", 128'(dsp_busy), 128'(m_owner >= 0));
    checkOutput("cyc_ins_l", 128'(dsp_ins_flat_l), 128'(el));
    checkOutput("cyc_ins_r", 128'(dsp_ins_flat_r), 128'(er));
    checkOutput("cyc_outs_l", 128'(client_outs_flat_l), 128'(dsp_outs_flat_l));
    checkOutput("cyc_outs_r", 128'(client_outs_flat_r), 128'(dsp_outs_flat_r));
    checkOutput("cyc_onehot", 128'($countones(client_grant) <= 1), 128'(1));
  end

  // Advance to just after the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req);
    client_req = req;
  endtask

  task automatic doReset();
    reset = 1'b1;
    client_req = '0;
    tick(2);
    reset = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int c = 0; c < N; c++) begin
      ins_l[c] = {8'(8'h40 + c), 18'(18'h100 + c), 18'(18'h2000 + c), 48'(48'hABCD_0000_0000 + c)};
      ins_r[c] = {8'(8'h80 + c), 18'(18'h300 + c), 18'(18'h3000 + c), 48'(48'h5555_0000_0000 + c)};
    end
    reset = 1'b1;
    tick(2);
    checkOutput("rst_grant", 128'(client_grant), 128'(0));
    checkOutput("rst_busy", 128'(dsp_busy), 128'(0));
    checkOutput("rst_owner", 128'(dsp_owner), 128'(0));
    checkOutput("rst_ins_l", 128'(dsp_ins_flat_l), 128'(NOP_BUS));
    reset = 1'b0;

    // Client 1 requests alone for 10 cycles.
    applyStimulus(4'b0010);
    checkOutput("t1_c0_grant", 128'(client_grant), 128'(0));
    tick(1);
    checkOutput("t1_c1_grant", 128'(client_grant), 128'(4'b0010));
    checkOutput("t1_c1_owner", 128'(dsp_owner), 128'(1));
    checkOutput("t1_c1_ins_l", 128'(dsp_ins_flat_l),
                128'({8'h41, 18'h00101, 18'h02001, 48'hABCD_0000_0001}));
    tick(9);
    applyStimulus(4'b0000);
    checkOutput("t1_c10_grant", 128'(client_grant), 128'(4'b0010));
    tick(1);
    checkOutput("t1_c11_grant", 128'(client_grant), 128'(0));
    checkOutput("t1_c11_ins_l", 128'(dsp_ins_flat_l), 128'(NOP_BUS));
    tick(2);

    // All four clients request together; each owner drops 3 cycles after
    // its grant.
    doReset();
    applyStimulus(4'b1111);
    for (int e = 0; e < N; e++) begin
      n = 0;
      while (!dsp_busy && n < 5) begin
        tick(1);
        n++;
      end
      checkOutput("t2_grant_order", 128'(client_grant), 128'(N'(1) << e));
      tick(3);
      client_req[e] = 1'b0;
      tick(1);
      checkOutput("t2_flush_grant", 128'(client_grant), 128'(0));
      checkOutput("t2_flush_ins_l", 128'(dsp_ins_flat_l), 128'(NOP_BUS));
      tick(1);
    end
    checkOutput("t2_done_busy", 128'(dsp_busy), 128'(0));

    // Client 2 holds while 0 and 3 request; then 3 is granted before 0.
    doReset();
    applyStimulus(4'b0100);
    tick(1);
    checkOutput("t3_grant2", 128'(client_grant), 128'(4'b0100));
    applyStimulus(4'b1101);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("t3_hold2", 128'(client_grant), 128'(4'b0100));
    end
    applyStimulus(4'b1001);
    tick(1);
    checkOutput("t3_flush_grant", 128'(client_grant), 128'(0));
    tick(1);
    checkOutput("t3_grant3", 128'(client_grant), 128'(4'b1000));
    checkOutput("t3_owner3", 128'(dsp_owner), 128'(3));
    tick(2);
    // Owner 3 drops while client 0 requests.
    applyStimulus(4'b0001);
    tick(1);
    checkOutput("t4_flush_grant", 128'(client_grant), 128'(0));
    checkOutput("t4_flush_ins_r", 128'(dsp_ins_flat_r), 128'(NOP_BUS));
    tick(1);
    checkOutput("t4_grant0", 128'(client_grant), 128'(4'b0001));
    checkOutput("t4_ins_r0", 128'(dsp_ins_flat_r),
                128'({8'h80, 18'h00300, 18'h03000, 48'h5555_0000_0000}));
    applyStimulus(4'b0000);
    tick(2);

    // P passthrough whatever the grant.
    dsp_outs_flat_l = 48'h0000_1234_5678;
    dsp_outs_flat_r = 48'hFEDC_0000_0001;
    #1;
    checkOutput("t5_outs_l_idle", 128'(client_outs_flat_l), 128'(48'h0000_1234_5678));
    checkOutput("t5_outs_r_idle", 128'(client_outs_flat_r), 128'(48'hFEDC_0000_0001));
    applyStimulus(4'b0010);
    tick(1);
    checkOutput("t5_grant1", 128'(client_grant), 128'(4'b0010));
    dsp_outs_flat_l = 48'h0000_0BAD_CAFE;
    #1;
    checkOutput("t5_outs_l_grant", 128'(client_outs_flat_l), 128'(48'h0000_0BAD_CAFE));

    // Reset in the middle of client 1's grant, with client 0 also asking.
    applyStimulus(4'b0011);
    tick(1);
    checkOutput("t6_hold1", 128'(client_grant), 128'(4'b0010));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_grant", 128'(client_grant), 128'(0));
    checkOutput("t6_rst_busy", 128'(dsp_busy), 128'(0));
    checkOutput("t6_rst_owner", 128'(dsp_owner), 128'(0));
    checkOutput("t6_rst_ins_l", 128'(dsp_ins_flat_l), 128'(NOP_BUS));
    tick(1);
    reset = 1'b0;
    tick(1);
    checkOutput("t6_grant0", 128'(client_grant), 128'(4'b0001));
    applyStimulus(4'b0000);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
